// File: rtl/vga_frame_sequencer.sv
// vga_frame_sequencer
//   Timing and sequencing controller for the PanelDisplay VGA datapath.
//   Produces the pixel strobe, raster counters, registered sync/active flags,
//   the frame-start pulse, and owns the pattern mode presented to the colour
//   datapath. The mode changes only inside vertical blanking, either from a
//   host request (cfg_req/cfg_ack handshake) or by auto-advance every
//   FRAMES_PER_MODE frames.
//   Optional build macro: FRAME_COUNTER_EN adds output frame_cnt[15:0], a
//   free-running count of frames since reset.
module vga_frame_sequencer #(
  parameter int PIX_DIV         = 2,
  parameter int H_VISIBLE       = 800,
  parameter int H_FP            = 56,
  parameter int H_SYNC          = 120,
  parameter int H_BP            = 64,
  parameter int V_VISIBLE       = 600,
  parameter int V_FP            = 37,
  parameter int V_SYNC          = 6,
  parameter int V_BP            = 23,
  parameter int FRAMES_PER_MODE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_en,
  input  logic        cfg_req,
  input  logic [1:0]  cfg_mode,
  output logic        cfg_ack,
  output logic        pix_en,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [1:0]  mode
`ifdef FRAME_COUNTER_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int FPM_W   = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [FPM_W-1:0] FPM_LAST = FPM_W'(FRAMES_PER_MODE - 1);

  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] X_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FP + H_SYNC - 1);

  localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0]  Y_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0]  VS_FIRST   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  // Host-request handshake states.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] r_div;
  logic             r_pix_en;
  logic [10:0]      r_x;
  logic [9:0]       r_y;
  logic             r_active;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_frame_start;

  state_t           r_state;
  logic             r_req_block;   // set by an accept, cleared once cfg_req drops
  logic             r_ack;
  logic [1:0]       r_mode;
  logic [FPM_W-1:0] r_fpm_cnt;     // frames elapsed in the current mode

  // ---------------------------------------------------------------------------
  // Combinational next values
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_pix_en_nxt;
  logic             w_x_wrap;
  logic [10:0]      w_x_nxt;
  logic [9:0]       w_y_nxt;

  logic             w_vblank;
  logic             w_vblank_entry;
  logic             w_load;
  state_t           w_state_nxt;

  // Next divider/raster position; all registered flags are derived from these
  // so that sync, active and frame_start line up with x/y without extra lag.
  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_div_nxt    = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    w_pix_en_nxt = (w_div_nxt == DIV_LAST);
    w_x_wrap     = r_pix_en && (r_x == X_LAST);
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    if (r_pix_en) begin
      w_x_nxt = w_x_wrap ? 11'd0 : r_x + 11'd1;
    end
    if (w_x_wrap) begin
      w_y_nxt = (r_y == Y_LAST) ? 10'd0 : r_y + 10'd1;
    end
  end

  // Raster state: divider, counters and the flags that describe the next position.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div         <= '0;
      r_pix_en      <= 1'b0;
      r_x           <= 11'd0;
      r_y           <= 10'd0;
      r_active      <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      r_pix_en      <= w_pix_en_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_active      <= (w_x_nxt < X_VIS) && (w_y_nxt < Y_VIS);
      r_hsync       <= !((w_x_nxt >= HS_FIRST) && (w_x_nxt <= HS_LAST));
      r_vsync       <= !((w_y_nxt >= VS_FIRST) && (w_y_nxt <= VS_LAST));
      // High during the strobe cycle whose edge wraps the raster to (0,0).
      r_frame_start <= w_pix_en_nxt && (w_x_nxt == X_LAST) && (w_y_nxt == Y_LAST);
    end
  end

  // Host-request FSM: accept immediately in vblank, otherwise wait for vblank.
  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_vblank       = (r_y >= Y_VIS);
    // Strobe edge that moves the raster from the last visible line into vblank.
    w_vblank_entry = w_x_wrap && (r_y == Y_VIS_LAST);
    case (r_state)
      ST_RUN: begin
        if (cfg_req && !r_req_block) begin
          if (w_vblank) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (!cfg_req) begin
          // Request withdrawn before it could be served: drop it.
          w_state_nxt = ST_RUN;
        end else if (w_vblank || w_vblank_entry) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Handshake registers: FSM state, accept pulse and the re-arm blocker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_ack       <= 1'b0;
      r_req_block <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack       <= w_load;
      r_req_block <= w_load || (r_req_block && cfg_req);
    end
  end

  // Pattern mode and per-mode frame count; a host load beats auto-advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode    <= 2'd0;
      r_fpm_cnt <= '0;
    end else if (w_load) begin
      r_mode    <= cfg_mode;
      r_fpm_cnt <= '0;
    end else if (r_frame_start) begin
      if (r_fpm_cnt == FPM_LAST) begin
        r_fpm_cnt <= '0;
        if (auto_en) begin
          r_mode <= r_mode + 2'd1;
        end
      end else begin
        r_fpm_cnt <= r_fpm_cnt + 1'b1;
      end
    end
  end

`ifdef FRAME_COUNTER_EN
  logic [15:0] r_frame_total;

  // Free-running frames-since-reset count, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_total <= 16'd0;
    end else if (r_frame_start) begin
      r_frame_total <= r_frame_total + 16'd1;
    end
  end

  assign frame_cnt = r_frame_total;
`endif

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign cfg_ack     = r_ack;
  assign pix_en      = r_pix_en;
  assign x           = r_x;
  assign y           = r_y;
  assign active      = r_active;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;
  assign mode        = r_mode;

endmodule
